// File: rtl/cpu_clint_pkg.sv
// cpu_clint_pkg
//   Shared definitions for the core-local interruptor: the register offsets
//   within the CLINT window and the register-select type with its decoder.
//   The offsets are the single source for software headers and the bus
//   decoder alike.
package cpu_clint_pkg;

    // Byte offsets within the CLINT window.
    localparam logic [15:0] CLINT_MSIP      = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP  = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMPH = 16'h4004;
    localparam logic [15:0] CLINT_MTIME     = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIMEH    = 16'hBFFC;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } reg_sel_e;

    // Decodes a 32-bit word address (byte offset with addr[1:0] dropped).
    function automatic reg_sel_e clint_decode(input logic [13:0] word_addr);
        reg_sel_e sel;
        sel = REG_NONE;
        if (word_addr == CLINT_MSIP[15:2])           sel = REG_MSIP;
        else if (word_addr == CLINT_MTIMECMP[15:2])  sel = REG_CMP_LO;
        else if (word_addr == CLINT_MTIMECMPH[15:2]) sel = REG_CMP_HI;
        else if (word_addr == CLINT_MTIME[15:2])     sel = REG_TIME_LO;
        else if (word_addr == CLINT_MTIMEH[15:2])    sel = REG_TIME_HI;
        return sel;
    endfunction

endpackage

// File: rtl/cpu_clint_if.sv
// cpu_clint_if
//   Data-bus slave port of the CLINT.
//   req    : access valid this cycle
//   we     : 1 = write, 0 = read
//   addr   : byte offset within the CLINT window (addr[1:0] ignored)
//   wdata  : write data
//   wmask  : byte enables for writes
//   rdata  : registered read data
//   rvalid : rdata valid, one cycle after a read req
interface cpu_clint_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [15:0]     addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wmask;
    logic [XLEN-1:0] rdata;
    logic            rvalid;

    modport master (
        output req, we, addr, wdata, wmask,
        input  rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata, wmask,
        output rdata, rvalid
    );
endinterface

// File: rtl/cpu_clint_prescaler.sv
// cpu_clint_prescaler
//   Divides the clock into mtime ticks: counts 0..TICK_DIV-1 and raises
//   tick during the wrap cycle. With TICK_DIV = 1 tick is permanently high.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   tick  : mtime increment enable
module cpu_clint_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/cpu_clint.sv
// cpu_clint
//   Core-local interruptor for the single-hart CPU: 64-bit mtime,
//   64-bit mtimecmp and the msip bit behind a memory-mapped slave port,
//   plus the registered interrupt lines into the CSR file.
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   bus         : data-bus slave port (cpu_clint_if.slave)
//   msi_pending : registered copy of msip[0]
//   mti_pending : registered result of mtime >= mtimecmp (unsigned)
module cpu_clint
    import cpu_clint_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    cpu_clint_if.slave bus,
    output logic       msi_pending,
    output logic       mti_pending
);

    logic            tick;
    reg_sel_e        sel;
    logic            wr_en;
    logic            rd_en;
    logic [7:0]      time_be;
    logic [7:0]      cmp_be;
    logic [63:0]     mtime_reg;
    logic [63:0]     mtime_inc;
    logic [63:0]     mtime_next;
    logic [63:0]     mtimecmp_reg;
    logic [63:0]     mtimecmp_next;
    logic            msip_reg;
    logic            msip_next;
    logic [31:0]     rd_val;
    logic [XLEN-1:0] rdata_reg;
    logic            rvalid_reg;
    logic            mti_reg;
    logic            msi_reg;
    logic            unused_addr_bits;

    cpu_clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign unused_addr_bits = ^bus.addr[1:0];

    assign sel   = clint_decode(bus.addr[15:2]);
    assign wr_en = bus.req & bus.we;
    assign rd_en = bus.req & ~bus.we;

    // Byte enables over the full 64-bit registers: the word select steers
    // wmask into the low or high half.
    assign time_be = {(wr_en && sel == REG_TIME_HI) ? bus.wmask : 4'b0,
                      (wr_en && sel == REG_TIME_LO) ? bus.wmask : 4'b0};
    assign cmp_be  = {(wr_en && sel == REG_CMP_HI)  ? bus.wmask : 4'b0,
                      (wr_en && sel == REG_CMP_LO)  ? bus.wmask : 4'b0};

    assign mtime_inc = tick ? (mtime_reg + 64'd1) : mtime_reg;

    // Written bytes override; every other byte of mtime takes the
    // incremented value, so a write during a tick keeps the carry intact
    // for the bytes software did not touch.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign mtime_next[8*gi +: 8]    = time_be[gi] ? bus.wdata[8*(gi%4) +: 8]
                                                          : mtime_inc[8*gi +: 8];
            assign mtimecmp_next[8*gi +: 8] = cmp_be[gi]  ? bus.wdata[8*(gi%4) +: 8]
                                                          : mtimecmp_reg[8*gi +: 8];
        end
    endgenerate

    assign msip_next = (wr_en && sel == REG_MSIP && bus.wmask[0]) ? bus.wdata[0] : msip_reg;

    // Read mux uses pre-edge state, so a read in a tick cycle sees old mtime.
    always_comb begin
        rd_val = 32'h0;
        case (sel)
            REG_MSIP:    rd_val = {31'b0, msip_reg};
            REG_CMP_LO:  rd_val = mtimecmp_reg[31:0];
            REG_CMP_HI:  rd_val = mtimecmp_reg[63:32];
            REG_TIME_LO: rd_val = mtime_reg[31:0];
            REG_TIME_HI: rd_val = mtime_reg[63:32];
            default:     rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
            msip_reg     <= 1'b0;
            rdata_reg    <= '0;
            rvalid_reg   <= 1'b0;
            mti_reg      <= 1'b0;
            msi_reg      <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            msip_reg     <= msip_next;
            rvalid_reg   <= rd_en;
            if (rd_en) begin
                rdata_reg <= XLEN'(rd_val);
            end
            // Pending lines follow register state one edge later.
            mti_reg      <= (mtime_reg >= mtimecmp_reg);
            msi_reg      <= msip_reg;
        end
    end

    assign bus.rdata   = rdata_reg;
    assign bus.rvalid  = rvalid_reg;
    assign mti_pending = mti_reg;
    assign msi_pending = msi_reg;

endmodule

// File: tb/tb_cpu_clint.sv
// tb_cpu_clint
//   Self-checking bench for cpu_clint. dut1 runs with TICK_DIV = 1 and is
//   tracked by a behavioural model; dut4 runs with TICK_DIV = 4 and is
//   checked against hand-derived constants.
module tb_cpu_clint;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cpu_clint_if #(.XLEN(32)) bus1 ();
    cpu_clint_if #(.XLEN(32)) bus4 ();

    logic msi1, mti1, msi4, mti4;

    cpu_clint #(.XLEN(32), .TICK_DIV(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus1),
        .msi_pending (msi1),
        .mti_pending (mti1)
    );

    cpu_clint #(.XLEN(32), .TICK_DIV(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus4),
        .msi_pending (msi4),
        .mti_pending (mti4)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model of dut1: architectural registers plus expected outputs.
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic [31:0] e_rdata;
    logic        e_rvalid;
    logic        e_mti;
    logic        e_msi;

    function automatic logic [31:0] apply_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  m);
        logic [31:0] bm;
        bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (old_v & ~bm) | (new_v & bm);
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        case (a & 16'hFFFC)
            16'h0000: return {31'b0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_time[31:0];
            16'hBFFC: return m_time[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_time   = 64'h0;
        m_cmp    = {64{1'b1}};
        m_msip   = 1'b0;
        e_rdata  = 32'h0;
        e_rvalid = 1'b0;
        e_mti    = 1'b0;
        e_msi    = 1'b0;
    endtask

    // Advance one clock edge, update the model from dut1's bus inputs,
    // then settle 1 time unit past the edge for sampling.
    task automatic step();
        logic [63:0] nt;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (bus1.req)
                $display("txn t=%0t %s addr=%h wdata=%h wmask=%h", $time,
                         bus1.we ? "WR" : "RD", bus1.addr, bus1.wdata, bus1.wmask);
            e_mti    = (m_time >= m_cmp);
            e_msi    = m_msip;
            e_rvalid = bus1.req && !bus1.we;
            if (e_rvalid) e_rdata = model_read(bus1.addr);
            nt = m_time + 64'd1;
            if (bus1.req && bus1.we) begin
                case (bus1.addr & 16'hFFFC)
                    16'h0000: if (bus1.wmask[0]) m_msip = bus1.wdata[0];
                    16'h4000: m_cmp[31:0]  = apply_bytes(m_cmp[31:0],  bus1.wdata, bus1.wmask);
                    16'h4004: m_cmp[63:32] = apply_bytes(m_cmp[63:32], bus1.wdata, bus1.wmask);
                    16'hBFF8: nt[31:0]     = apply_bytes(nt[31:0],     bus1.wdata, bus1.wmask);
                    16'hBFFC: nt[63:32]    = apply_bytes(nt[63:32],    bus1.wdata, bus1.wmask);
                    default: ;
                endcase
            end
            m_time = nt;
        end
        #1;
    endtask

    task automatic drv(input logic r, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        bus1.req   = r;
        bus1.we    = w;
        bus1.addr  = a;
        bus1.wdata = d;
        bus1.wmask = m;
    endtask

    task automatic idle();                   drv(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); endtask
    task automatic rd(input logic [15:0] a); drv(1'b1, 1'b0, a, 32'h0, 4'h0);     endtask
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        drv(1'b1, 1'b1, a, d, m);
    endtask

    task automatic drv4(input logic r, input logic [15:0] a);
        bus4.req   = r;
        bus4.we    = 1'b0;
        bus4.addr  = a;
        bus4.wdata = 32'h0;
        bus4.wmask = 4'h0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic seen;
        total++;
        if ({bus1.rvalid, bus1.rdata, mti1, msi1} !== 35'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rvalid=%b rdata=%h mti=%b msi=%b required all 0",
                     bus1.rvalid, bus1.rdata, mti1, msi1);
        end
        rst_n = 1'b1;
        rd(16'hBFF8); step();
        total++;
        if (bus1.rvalid !== 1'b1 || bus1.rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mtime: got rvalid=%b rdata=%h required 1/00000000", bus1.rvalid, bus1.rdata);
        end
        rd(16'h4004); step();
        total++;
        if (bus1.rdata !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL reset_mtimecmph: got %h required ffffffff", bus1.rdata);
        end
        rd(16'h0000); step();
        total++;
        if (bus1.rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_msip: got %h required 00000000", bus1.rdata);
        end
        idle();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (mti1 !== 1'b0 || msi1 !== 1'b0 || mti4 !== 1'b0 || msi4 !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_pending_quiet: got a pending output high, required 0 for 100 cycles");
        end
    endtask

    task automatic test_tick_div4();
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        repeat (40) step();
        drv4(1'b1, 16'hBFF8); step(); drv4(1'b0, 16'h0);
        total++;
        if (bus4.rvalid !== 1'b1 || bus4.rdata !== 32'h0000_000A) begin
            bad++;
            $display("FAIL div4_count: got rvalid=%b rdata=%h required 1/0000000a", bus4.rvalid, bus4.rdata);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({bus4.rvalid, bus4.rdata, mti4, msi4, bus1.rvalid, bus1.rdata} !== 68'h0) begin
            bad++;
            $display("FAIL async_reset: got rvalid4=%b rdata4=%h mti4=%b msi4=%b rvalid1=%b rdata1=%h required all 0",
                     bus4.rvalid, bus4.rdata, mti4, msi4, bus1.rvalid, bus1.rdata);
        end
        rst_n = 1'b1;
        drv4(1'b1, 16'hBFF8); step(); drv4(1'b0, 16'h0);
        total++;
        if (bus4.rvalid !== 1'b1 || bus4.rdata !== 32'h0) begin
            bad++;
            $display("FAIL div4_after_reset: got rvalid=%b rdata=%h required 1/00000000", bus4.rvalid, bus4.rdata);
        end
        repeat (5) step();
        drv4(1'b1, 16'hBFF8); step(); drv4(1'b0, 16'h0);
        total++;
        if (bus4.rdata !== 32'h1) begin
            bad++;
            $display("FAIL div4_first_tick: got %h required 00000001", bus4.rdata);
        end
    endtask

    task automatic test_mti();
        logic exp;
        wr(16'h4004, 32'h0, 4'hF); step();
        wr(16'h4000, 32'h5, 4'hF); step();
        wr(16'hBFFC, 32'h0, 4'hF); step();
        wr(16'hBFF8, 32'h0, 4'hF); step();
        idle();
        // mtime is 0 now; after edge k it has been k-1 before that edge.
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = (k >= 6);
            total++;
            if (mti1 !== exp) begin
                bad++;
                $display("FAIL mti_rise k=%0d: got %b required %b", k, mti1, exp);
            end
        end
        wr(16'h4004, 32'h1, 4'hF); step(); idle();
        total++;
        if (mti1 !== 1'b1) begin
            bad++;
            $display("FAIL mti_hold: got %b required 1", mti1);
        end
        step();
        total++;
        if (mti1 !== 1'b0) begin
            bad++;
            $display("FAIL mti_fall: got %b required 0", mti1);
        end
    endtask

    task automatic test_carry();
        logic [31:0] exp_v [0:5];
        logic [15:0] ra    [0:5];
        exp_v = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h1};
        ra    = '{16'hBFF8, 16'hBFFC, 16'hBFF8, 16'hBFFC, 16'hBFFC, 16'hBFF8};
        wr(16'hBFFC, 32'h0, 4'hF);         step();
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF); step();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF); step();
                wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF); step();
            end
            rd(ra[i]); step();
            total++;
            if (bus1.rdata !== exp_v[i]) begin
                bad++;
                $display("FAIL carry_wrap[%0d] addr=%h: got %h required %h", i, ra[i], bus1.rdata, exp_v[i]);
            end
        end
        idle();
    endtask

    task automatic test_partial();
        logic [31:0] old_lo, exp;
        old_lo = m_time[31:0];
        wr(16'hBFF8, 32'h1234_5678, 4'h3); step();
        rd(16'hBFF8); step(); idle();
        exp = ((old_lo + 32'd1) & 32'hFFFF_0000) | 32'h0000_5678;
        total++;
        if (bus1.rdata !== exp) begin
            bad++;
            $display("FAIL partial_mtime_write: got %h required %h", bus1.rdata, exp);
        end
    endtask

    task automatic test_msip();
        wr(16'h0000, 32'hFFFF_FFFF, 4'h2); step(); idle(); step(); step();
        total++;
        if (msi1 !== 1'b0) begin
            bad++;
            $display("FAIL msip_mask2: got %b required 0", msi1);
        end
        wr(16'h0000, 32'hFFFF_FFFF, 4'h1); step(); idle();
        total++;
        if (msi1 !== 1'b0) begin
            bad++;
            $display("FAIL msip_early: got %b required 0", msi1);
        end
        step();
        total++;
        if (msi1 !== 1'b1) begin
            bad++;
            $display("FAIL msip_set: got %b required 1", msi1);
        end
        rd(16'h0000); step();
        total++;
        if (bus1.rdata !== 32'h1) begin
            bad++;
            $display("FAIL msip_read: got %h required 00000001", bus1.rdata);
        end
        rd(16'h1234); step();
        total++;
        if (bus1.rvalid !== 1'b1 || bus1.rdata !== 32'h0) begin
            bad++;
            $display("FAIL unmapped_read: got rvalid=%b rdata=%h required 1/00000000", bus1.rvalid, bus1.rdata);
        end
        wr(16'h0000, 32'h0, 4'h0); step(); idle(); step();
        total++;
        if (msi1 !== 1'b1) begin
            bad++;
            $display("FAIL msip_mask0_noop: got %b required 1", msi1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq_a [0:3];
        seq_a = '{16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
        for (int i = 0; i < 4; i++) begin
            rd(seq_a[i]); step();
            total++;
            if (bus1.rvalid !== 1'b1 || bus1.rdata !== e_rdata) begin
                bad++;
                $display("FAIL b2b_read[%0d]: got rvalid=%b rdata=%h required 1/%h", i, bus1.rvalid, bus1.rdata, e_rdata);
            end
        end
        wr(16'h4000, 32'hAAAA_5555, 4'hF); step(); idle();
        total++;
        if (bus1.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_rvalid_drop: got %b required 0", bus1.rvalid);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [31:0] d;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 6))
                0: a = 16'h0000;
                1: a = 16'h4000;
                2: a = 16'h4004;
                3: a = 16'hBFF8;
                4: a = 16'hBFFC;
                5: a = 16'h4000 | 16'($urandom_range(0, 3));
                default: a = 16'($urandom_range(0, 65535));
            endcase
            d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300));
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d, 4'($urandom_range(0, 15)));
            step();
            total++;
            if (bus1.rvalid !== e_rvalid) begin
                bad++;
                $display("FAIL rand_rvalid n=%0d: got %b required %b", n, bus1.rvalid, e_rvalid);
            end
            if (e_rvalid) begin
                total++;
                if (bus1.rdata !== e_rdata) begin
                    bad++;
                    $display("FAIL rand_rdata n=%0d: got %h required %h", n, bus1.rdata, e_rdata);
                end
            end
            total++;
            if (mti1 !== e_mti || msi1 !== e_msi) begin
                bad++;
                $display("FAIL rand_pending n=%0d: got mti=%b msi=%b required %b/%b", n, mti1, msi1, e_mti, e_msi);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        drv4(1'b0, 16'h0);
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) step();
        test_reset();
        test_tick_div4();
        test_mti();
        test_carry();
        test_partial();
        test_msip();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
